// File: rtl/mac_serial.sv
// Nibble-serial multiply-accumulate: operand pairs arrive LSB nibble first,
// products accumulate into a guarded accumulator, and the result streams out nibble-serially.
module mac_serial #(
  parameter int BIT_WIDTH  = 16,
  parameter int GUARD_BITS = 8,
  parameter bit SIGNED     = 1'b0,
  parameter bit SATURATE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_out_valid,
  output logic       result_complete,
  output logic       ready,
  output logic       overflow
);

  localparam int N_IN      = BIT_WIDTH / 4;
  localparam int ACC_WIDTH = 2 * BIT_WIDTH + GUARD_BITS;
  localparam int N_OUT     = ACC_WIDTH / 4;
  localparam int CNT_W     = $clog2(2 * N_IN);
  localparam int OCNT_W    = $clog2(N_OUT);
  localparam int EXT_W     = ACC_WIDTH - BIT_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, OUTPUT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OCNT_W-1:0]      outCnt_q, outCnt_d;
  logic [BIT_WIDTH-1:0]   a_q, a_d;
  logic [BIT_WIDTH-5:0]   b_q, b_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;

  logic [BIT_WIDTH-1:0]   bFull;
  logic [ACC_WIDTH-1:0]   aExt, bExt, prod, satVal, accNew;
  logic [ACC_WIDTH:0]     sum;
  logic                   sumOvf;

  // Product of the completed pair; b's top nibble comes straight off the bus.
  always_comb begin
    bFull = {data_in, b_q};
    aExt  = SIGNED ? {{EXT_W{a_q[BIT_WIDTH-1]}}, a_q}   : {{EXT_W{1'b0}}, a_q};
    bExt  = SIGNED ? {{EXT_W{bFull[BIT_WIDTH-1]}}, bFull} : {{EXT_W{1'b0}}, bFull};
    prod  = aExt * bExt;
    sum   = {1'b0, acc_q} + {1'b0, prod};
    if (SIGNED)
      sumOvf = (acc_q[ACC_WIDTH-1] == prod[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    else
      sumOvf = sum[ACC_WIDTH];
    // On signed overflow the true sum has the sign shared by both addends.
    if (SIGNED)
      satVal = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      satVal = {ACC_WIDTH{1'b1}};
    accNew = (sumOvf && SATURATE) ? satVal : sum[ACC_WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    outCnt_d = outCnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          cnt_d    = CNT_W'(1);
          a_d      = {data_in, a_q[BIT_WIDTH-1:4]};
          acc_d    = '0;
          ovf_d    = 1'b0;
          outCnt_d = '0;
        end
      end
      LOAD: begin
        if (cnt_q < CNT_W'(N_IN)) begin
          a_d   = {data_in, a_q[BIT_WIDTH-1:4]};
          cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q != CNT_W'(2 * N_IN - 1)) begin
          b_d   = (b_q >> 4) | ((BIT_WIDTH-4)'(data_in) << (BIT_WIDTH - 8));
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          acc_d = accNew;
          ovf_d = ovf_q | sumOvf;
          cnt_d = '0;
          if (start) begin
            state_d  = OUTPUT;
            outCnt_d = '0;
          end
        end
      end
      OUTPUT: begin
        acc_d    = acc_q >> 4;
        outCnt_d = outCnt_q + OCNT_W'(1);
        if (outCnt_q == OCNT_W'(N_OUT - 1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      outCnt_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      outCnt_q <= outCnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  // The accumulator shifts right during OUTPUT, so its low nibble is the current result nibble.
  assign ready           = (state_q == IDLE);
  assign data_out_valid  = (state_q == OUTPUT);
  assign data_out        = data_out_valid ? acc_q[3:0] : 4'h0;
  assign result_complete = data_out_valid && (outCnt_q == OCNT_W'(N_OUT - 1));
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_mac_serial.sv
// Directed self-checking bench for mac_serial across four parameter sets.
module tb_mac_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] data_in = 4'h0;

  logic [3:0] dOut [4];
  logic       dVal [4];
  logic       rCmp [4];
  logic       rdy  [4];
  logic       ovf  [4];

  int sel = 0;
  int checks = 0;
  int failures = 0;
  int lowCnt = 0;

  logic [3:0] obsData;
  logic       obsValid, obsComplete, obsReady, obsOvf;

  always #5 clk = ~clk;

  // u0: defaults, u1: signed, u2: 8-bit wrapping, u3: 8-bit saturating
  mac_serial u0 (.clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .data_out(dOut[0]), .data_out_valid(dVal[0]), .result_complete(rCmp[0]),
    .ready(rdy[0]), .overflow(ovf[0]));
  mac_serial #(.SIGNED(1'b1)) u1 (.clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .data_out(dOut[1]), .data_out_valid(dVal[1]), .result_complete(rCmp[1]),
    .ready(rdy[1]), .overflow(ovf[1]));
  mac_serial #(.BIT_WIDTH(8), .GUARD_BITS(0), .SATURATE(1'b0)) u2 (.clk(clk), .rst(rst),
    .start(start), .data_in(data_in), .data_out(dOut[2]), .data_out_valid(dVal[2]),
    .result_complete(rCmp[2]), .ready(rdy[2]), .overflow(ovf[2]));
  mac_serial #(.BIT_WIDTH(8), .GUARD_BITS(0), .SATURATE(1'b1)) u3 (.clk(clk), .rst(rst),
    .start(start), .data_in(data_in), .data_out(dOut[3]), .data_out_valid(dVal[3]),
    .result_complete(rCmp[3]), .ready(rdy[3]), .overflow(ovf[3]));

  // Route the selected instance's outputs to a single set of observation signals.
  always_comb begin
    obsData     = dOut[sel];
    obsValid    = dVal[sel];
    obsComplete = rCmp[sel];
    obsReady    = rdy[sel];
    obsOvf      = ovf[sel];
  end

  // Count busy cycles, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (!obsReady) lowCnt <= lowCnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair, LSB nibble first; start on nibble 0 of the first pair,
  // on the final b nibble of the last pair, and optionally on a mid-pair nibble.
  task automatic applyStimulus(input int nIn, input logic [15:0] a, input logic [15:0] b,
                               input bit first, input bit last, input bit midStart);
    for (int i = 0; i < 2 * nIn; i++) begin
      data_in = (i < nIn) ? a[4*i +: 4] : b[4*(i-nIn) +: 4];
      start   = (i == 0 && first) || (i == 2 * nIn - 1 && last) ||
                (midStart && (i == 2 || i == nIn + 1));
      step();
    end
    start   = 1'b0;
    data_in = 4'h0;
  endtask

  task automatic checkOutput(input string tag, input int nOut, input logic [39:0] expVal,
                             input logic expOvf);
    logic [39:0] got;
    int badVal, badCmp;
    got = '0;
    badVal = 0;
    badCmp = 0;
    chk({tag, "_validLatency"}, obsValid, 1'b1);
    for (int k = 0; k < nOut; k++) begin
      if (obsValid !== 1'b1) badVal++;
      if (obsComplete !== (k == nOut - 1)) badCmp++;
      got[4*k +: 4] = obsData;
      step();
    end
    chk({tag, "_value"}, got, expVal);
    chk({tag, "_validWindow"}, badVal, 0);
    chk({tag, "_completePulse"}, badCmp, 0);
    chk({tag, "_validLow"}, obsValid, 1'b0);
    chk({tag, "_readyAfter"}, obsReady, 1'b1);
    chk({tag, "_overflow"}, obsOvf, expOvf);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    step();
    rst = 1'b0;
    step();
    sel = 0;
    chk("reset_ready", obsReady, 1'b1);
    chk("reset_valid", obsValid, 1'b0);
    chk("reset_data", obsData, 4'h0);
    chk("reset_complete", obsComplete, 1'b0);
    chk("reset_overflow", obsOvf, 1'b0);

    // Three unsigned pairs summing to 68; also measure busy duration.
    lowCnt = 0;
    applyStimulus(4, 16'd2, 16'd3, 1, 0, 0);
    applyStimulus(4, 16'd4, 16'd5, 0, 0, 0);
    applyStimulus(4, 16'd6, 16'd7, 0, 1, 0);
    checkOutput("u3pairs", 10, 40'h0000000044, 1'b0);
    chk("u3pairs_busyCycles", lowCnt, 2 * 4 * 3 - 1 + 10);

    applyStimulus(4, 16'hFFFF, 16'hFFFF, 1, 1, 0);
    checkOutput("uMaxPair", 10, 40'h00FFFE0001, 1'b0);

    sel = 1;
    doReset();
    applyStimulus(4, 16'hFFFD, 16'd5, 1, 0, 0);
    applyStimulus(4, 16'd2, 16'd4, 0, 1, 0);
    checkOutput("sNeg7", 10, 40'hFFFFFFFFF9, 1'b0);
    applyStimulus(4, 16'h8000, 16'h8000, 1, 1, 0);
    checkOutput("sMinSq", 10, 40'h0040000000, 1'b0);

    sel = 2;
    doReset();
    applyStimulus(2, 16'hFF, 16'hFF, 1, 0, 0);
    applyStimulus(2, 16'hFF, 16'hFF, 0, 1, 0);
    checkOutput("w8wrap", 4, 40'hFC02, 1'b1);

    sel = 3;
    doReset();
    applyStimulus(2, 16'hFF, 16'hFF, 1, 0, 0);
    applyStimulus(2, 16'hFF, 16'hFF, 0, 1, 0);
    checkOutput("w8sat", 4, 40'hFFFF, 1'b1);
    applyStimulus(2, 16'd1, 16'd1, 1, 1, 0);
    checkOutput("w8clearOvf", 4, 40'h0001, 1'b0);

    // Mid-pair start pulses must not end the operation early.
    sel = 0;
    doReset();
    applyStimulus(4, 16'd2, 16'd3, 1, 0, 1);
    chk("midStart_stillLoading", obsReady, 1'b0);
    chk("midStart_noValid", obsValid, 1'b0);
    applyStimulus(4, 16'd4, 16'd5, 0, 1, 1);
    checkOutput("midStart", 10, 40'h000000001A, 1'b0);

    // Reset in the middle of the second pair's b nibbles discards everything.
    applyStimulus(4, 16'd2, 16'd3, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      data_in = 4'h1;
      step();
    end
    rst = 1'b1;
    #1;
    chk("midRst_ready", obsReady, 1'b1);
    chk("midRst_valid", obsValid, 1'b0);
    chk("midRst_data", obsData, 4'h0);
    chk("midRst_complete", obsComplete, 1'b0);
    chk("midRst_overflow", obsOvf, 1'b0);
    step();
    rst = 1'b0;
    begin
      int sawValid;
      sawValid = 0;
      for (int i = 0; i < 12; i++) begin
        if (obsValid !== 1'b0) sawValid++;
        step();
      end
      chk("midRst_noOutput", sawValid, 0);
    end
    applyStimulus(4, 16'd1, 16'd1, 1, 1, 0);
    checkOutput("afterRst", 10, 40'h0000000001, 1'b0);

    // Back-to-back operations: second start in the first ready cycle.
    lowCnt = 0;
    applyStimulus(4, 16'd2, 16'd3, 1, 1, 0);
    checkOutput("b2bFirst", 10, 40'h0000000006, 1'b0);
    chk("b2bFirst_busyCycles", lowCnt, 2 * 4 * 1 - 1 + 10);
    lowCnt = 0;
    applyStimulus(4, 16'd1, 16'd1, 1, 0, 0);
    applyStimulus(4, 16'd2, 16'd2, 0, 1, 0);
    checkOutput("b2bSecond", 10, 40'h0000000005, 1'b0);
    chk("b2bSecond_busyCycles", lowCnt, 2 * 4 * 2 - 1 + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
